// File: rtl/pcie_rq_inv_cpl_arb.sv
// pcie_rq_inv_cpl_arb
// Buffers single-beat Invalidation Completion TLPs from the CQ ATS snooper and
// merges them with the user RQ stream into one RQ AXI-stream for the PCIe core.
// Arbitration changes owner only at packet boundaries. Completions arriving
// while the FIFO is full are discarded.
// Optional build macro RQ_INV_DROP_CNT_EN: keeps the saturating drop counter;
// when undefined, inv_drop_cnt reads as zero and the counter is not built.
module pcie_rq_inv_cpl_arb #(
   parameter int AXIS_DATA_WIDTH = 512,
   parameter int RQ_TUSER_WIDTH  = 137,
   parameter int INV_FIFO_DEPTH  = 8,
   parameter int INV_MAX_BURST   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [AXIS_DATA_WIDTH-1:0]    s_inv_tdata,
   input  logic                          s_inv_tvalid,
   output logic                          s_inv_tready,
   input  logic [AXIS_DATA_WIDTH-1:0]    s_usr_tdata,
   input  logic [AXIS_DATA_WIDTH/8-1:0]  s_usr_tkeep,
   input  logic [RQ_TUSER_WIDTH-1:0]     s_usr_tuser,
   input  logic                          s_usr_tlast,
   input  logic                          s_usr_tvalid,
   output logic                          s_usr_tready,
   output logic [AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
   output logic [RQ_TUSER_WIDTH-1:0]     m_axis_tuser,
   output logic                          m_axis_tlast,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic [15:0]                   inv_drop_cnt,
   output logic [$clog2(INV_FIFO_DEPTH):0] inv_fifo_level
);

   localparam int AW = $clog2(INV_FIFO_DEPTH);
   localparam int BW = $clog2(INV_MAX_BURST + 1);
   localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);
   localparam logic [BW-1:0] BURST_ONE = BW'(1);
   localparam logic [BW-1:0] BURST_MAX = BW'(INV_MAX_BURST);

   typedef enum logic [1:0] {IDLE, USR, INV} state_t;

   logic [127:0]  mem [INV_FIFO_DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr;
   logic          fifo_full, fifo_empty;
   logic          wr_en, pop, avail_next;
   logic [127:0]  head;
   state_t        state, state_next;
   logic [BW-1:0] burst, burst_next;
   logic          decide;

   // Only the low 128 bits of a completion beat carry the TLP.
   logic unused_inv_bits;
   assign unused_inv_bits = ^s_inv_tdata[AXIS_DATA_WIDTH-1:128];

   // Extra pointer MSB distinguishes a full FIFO from an empty one.
   assign fifo_empty     = (wr_ptr == rd_ptr);
   assign fifo_full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign inv_fifo_level = wr_ptr - rd_ptr;
   assign s_inv_tready   = !fifo_full;
   assign head           = mem[rd_ptr[AW-1:0]];

   // A beat while full is dropped even if a pop happens in the same cycle.
   assign wr_en = s_inv_tvalid && !fifo_full;
   assign pop   = (state == INV) && m_axis_tready;

   // Looks one cycle ahead so a beat written now can be granted next cycle.
   assign avail_next = wr_en || (!fifo_empty && !(pop && (inv_fifo_level == PTR_ONE)));

   // Completion storage.
   // NOTE: the storage array is not reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= s_inv_tdata[127:0];
   end

   // FIFO pointers; reset flushes the FIFO.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Arbiter state and inv burst counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         burst <= '0;
      end else begin
         state <= state_next;
         burst <= burst_next;
      end
   end

   // Next-state decision and state-selected output mux.
   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_next    = state;
      burst_next    = burst;
      decide        = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tkeep  = '0;
      m_axis_tuser  = '0;
      m_axis_tlast  = 1'b0;
      m_axis_tvalid = 1'b0;
      s_usr_tready  = 1'b0;
      case (state)
         IDLE: decide = 1'b1;
         INV: begin
            m_axis_tdata[127:0] = head;
            m_axis_tkeep        = '1;
            m_axis_tlast        = 1'b1;
            m_axis_tvalid       = 1'b1;
            if (m_axis_tready) begin
               if (s_usr_tvalid && (burst != BURST_MAX)) burst_next = burst + BURST_ONE;
               decide = 1'b1;
            end
         end
         USR: begin
            m_axis_tdata  = s_usr_tdata;
            m_axis_tkeep  = s_usr_tkeep;
            m_axis_tuser  = s_usr_tuser;
            m_axis_tlast  = s_usr_tlast;
            m_axis_tvalid = s_usr_tvalid;
            s_usr_tready  = m_axis_tready;
            if (s_usr_tvalid && m_axis_tready && s_usr_tlast) begin
               burst_next = '0;
               decide     = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
      // Packet-boundary arbitration: inv wins unless the user has waited a full burst.
      if (decide) begin
         if (avail_next && (!s_usr_tvalid || (burst_next < BURST_MAX))) begin
            state_next = INV;
         end else if (s_usr_tvalid) begin
            state_next = USR;
            burst_next = '0;
         end else begin
            state_next = IDLE;
         end
      end
   end

`ifdef RQ_INV_DROP_CNT_EN
   logic [15:0] drop_cnt;

   // Count completions discarded on a full FIFO, saturating at all ones.
   always_ff @(posedge clk) begin
      if (rst)                                                drop_cnt <= '0;
      else if (s_inv_tvalid && fifo_full && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
   end

   assign inv_drop_cnt = drop_cnt;
`else
   assign inv_drop_cnt = 16'd0;
`endif

endmodule
